osmlgd_frame_loader: RTL

Upstream input stage for `osmlgd_top`. It accepts a received codeword as a stream of narrow beats over a valid/ready handshake and assembles it into a 256-bit frame. It then presents the frame on `tx` with a one-cycle `work` pulse whenever the decoder reports `free`. A two-deep buffer (fill + hold) lets the next codeword stream in while the current one waits for the decoder.

---
 rtl/osmlgd_frame_loader.sv | 136 +++++++++++++
 1 files changed

// File: rtl/osmlgd_frame_loader.sv
// Beat-to-frame assembler feeding the OSMLGD decoder through a fill + hold buffer pair.
// Optional s_last framing check: define OSMLGD_LOADER_LASTCHK_EN.
module osmlgd_frame_loader #(
  parameter int FRAME_W = 256,
  parameter int BEAT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BEAT_W-1:0]  s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  input  logic               free,
  output logic               work,
  output logic [FRAME_W-1:0] tx,
  output logic               frame_err,
  output logic [15:0]        frame_cnt
);
  localparam int BEATS = FRAME_W / BEAT_W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD} state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] fill_q, fill_d, hold_q, hold_d, tx_q, tx_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               fill_full_q, fill_full_d, hold_v_q, hold_v_d;
  logic               work_q, work_d, frame_err_q, frame_err_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic               accept, is_last, issue, hold_free, bad;
  logic [FRAME_W-1:0] fill_w;

`ifdef OSMLGD_LOADER_LASTCHK_EN
  assign bad = accept && (s_last != is_last);
`else
  logic unused_last;
  assign unused_last = s_last;
  assign bad = 1'b0;
`endif

  assign accept    = s_valid && !fill_full_q;
  assign is_last   = (idx_q == IDX_W'(BEATS-1));
  assign issue     = (state_q == IDLE) && hold_v_q && free;
  // hold can take a new frame if empty or being issued on this same edge
  assign hold_free = !hold_v_q || issue;

  always_comb begin
    fill_w = fill_q;
    fill_w[int'(idx_q)*BEAT_W +: BEAT_W] = s_data;
  end

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    hold_d      = hold_q;
    tx_d        = tx_q;
    idx_d       = idx_q;
    fill_full_d = fill_full_q;
    hold_v_d    = hold_v_q;
    work_d      = 1'b0;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: if (issue) begin
        work_d      = 1'b1;
        tx_d        = hold_q;
        hold_v_d    = 1'b0;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = ISSUE;
      end
      ISSUE:   state_d = GUARD;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fill_full_q && hold_free) begin
      hold_d      = fill_q;
      hold_v_d    = 1'b1;
      fill_full_d = 1'b0;
    end

    // accept is never high while fill_full_q, so the two loads into hold are exclusive
    if (accept) begin
      if (bad) begin
        idx_d       = '0;
        frame_err_d = 1'b1;
      end else if (is_last) begin
        idx_d = '0;
        if (hold_free) begin
          hold_d   = fill_w;
          hold_v_d = 1'b1;
        end else begin
          fill_d      = fill_w;
          fill_full_d = 1'b1;
        end
      end else begin
        fill_d = fill_w;
        idx_d  = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      hold_q      <= '0;
      tx_q        <= '0;
      idx_q       <= '0;
      fill_full_q <= 1'b0;
      hold_v_q    <= 1'b0;
      work_q      <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      hold_q      <= hold_d;
      tx_q        <= tx_d;
      idx_q       <= idx_d;
      fill_full_q <= fill_full_d;
      hold_v_q    <= hold_v_d;
      work_q      <= work_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s_ready   = !fill_full_q;
  assign work      = work_q;
  assign tx        = tx_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;
endmodule
